// File: rtl/capsule_8bit_expander_pkg.sv
// Shared definitions for the 8-coefficient capsule expander.
// Holds the width constants, the entry field offsets, the expander state
// enum and helpers that pull one entry's fields out of the packed array.
package capsule_8bit_expander_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned RUN_W   = 6;
  localparam int unsigned ENTRY_W = RUN_W + DATA_W;
  localparam int unsigned ROW_LEN = 8;
  localparam int unsigned ARRAY_W = ENTRY_W * ROW_LEN;

  // Entry layout: {run[13:8], value[7:0]}
  localparam int unsigned VALUE_LSB = 0;
  localparam int unsigned RUN_LSB   = DATA_W;

  typedef enum logic [2:0] {
    IDLE,
    ZERO,
    LEAD,
    VALUE,
    GAP,
    TRAIL
  } state_t;

  function automatic logic [RUN_W-1:0] entry_run(input logic [ARRAY_W-1:0] arr,
                                                 input logic [2:0]         k);
    return arr[32'(k)*ENTRY_W + RUN_LSB +: RUN_W];
  endfunction

  function automatic logic [DATA_W-1:0] entry_value(input logic [ARRAY_W-1:0] arr,
                                                    input logic [2:0]         k);
    return arr[32'(k)*ENTRY_W + VALUE_LSB +: DATA_W];
  endfunction

endpackage

// File: rtl/capsule_8bit_expander_check.sv
// capsule_check: combinational validity test for one packed capsule.
// Ports:
//   flag, left, right, size, arr : capsule fields as presented at the input
//   ok                           : 1 when the capsule describes exactly 8 bytes
// A flag=0 capsule is always accepted. The length sum is kept wide enough
// that six-bit runs can never wrap back onto 8.
module capsule_check
  import capsule_8bit_expander_pkg::*;
(
  input  logic               flag,
  input  logic [2:0]         left,
  input  logic [2:0]         right,
  input  logic [3:0]         size,
  input  logic [ARRAY_W-1:0] arr,
  output logic               ok
);

  logic [9:0] sum;
  logic       last_run_zero;

  always_comb begin
    sum           = 10'(left) + 10'(right) + 10'(size);
    last_run_zero = 1'b0;
    for (int unsigned j = 0; j < ROW_LEN; j++) begin
      if (j + 1 < 32'(size))
        sum = sum + 10'(entry_run(arr, 3'(j)));
      if (j + 1 == 32'(size))
        last_run_zero = (entry_run(arr, 3'(j)) == '0);
    end
    ok = !flag ||
         (size >= 4'd1 && size <= 4'd8 && last_run_zero && sum == 10'd8);
  end

endmodule

// File: rtl/capsule_8bit_expander.sv
// capsule_8bit_expander: rebuilds 8 coefficient bytes from one run-length
// capsule and streams them out, byte 7 first.
// Ports:
//   clk, rst_n                    : clock, synchronous active-low reset
//   in_valid/in_ready             : capsule handshake (ready only when idle)
//   in_flag/left/right/array/size : packed capsule
//   out_valid/out_ready           : byte stream handshake
//   out_data, out_idx, out_last   : byte, its index (7..0), last-byte marker
//   err                           : one-cycle pulse when a malformed capsule is dropped
module capsule_8bit_expander
  import capsule_8bit_expander_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_flag,
  input  logic [2:0]         in_left,
  input  logic [2:0]         in_right,
  input  logic [ARRAY_W-1:0] in_array,
  input  logic [3:0]         in_size,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [2:0]         out_idx,
  output logic               out_last,
  output logic               err
);

  state_t             state, state_nx;
  logic [3:0]         cnt, cnt_nx;
  logic [2:0]         k, k_nx;
  logic [ARRAY_W-1:0] arr_q;
  logic [2:0]         right_q;
  logic               ok;
  logic               accept;
  logic               fire;
  logic [RUN_W-1:0]   gap_run;

  capsule_check u_check (
    .flag  (in_flag),
    .left  (in_left),
    .right (in_right),
    .size  (in_size),
    .arr   (in_array),
    .ok    (ok)
  );

  assign in_ready  = rst_n && (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state != IDLE);
  assign fire      = out_valid && out_ready;
  // Outputs derive from registered state only, so they hold during stalls.
  assign out_data  = (state == VALUE) ? entry_value(arr_q, k) : '0;
  assign out_last  = (out_idx == 3'd0);
  assign gap_run   = entry_run(arr_q, k - 3'd1);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    k_nx     = k;
    case (state)
      IDLE: begin
        if (accept && ok) begin
          if (!in_flag) begin
            state_nx = ZERO;
            cnt_nx   = 4'd8;
          end else begin
            cnt_nx   = {1'b0, in_left};
            k_nx     = 3'(in_size - 4'd1);
            state_nx = (in_left == 3'd0) ? VALUE : LEAD;
          end
        end
      end
      ZERO, LEAD, GAP, TRAIL: begin
        if (fire) begin
          cnt_nx = cnt - 4'd1;
          if (cnt == 4'd1)
            state_nx = (state == LEAD || state == GAP) ? VALUE : IDLE;
        end
      end
      VALUE: begin
        if (fire) begin
          if (k == 3'd0) begin
            if (right_q == 3'd0) begin
              state_nx = IDLE;
            end else begin
              state_nx = TRAIL;
              cnt_nx   = {1'b0, right_q};
            end
          end else begin
            k_nx = k - 3'd1;
            // An accepted capsule bounds every run to at most 6.
            if (gap_run != '0) begin
              state_nx = GAP;
              cnt_nx   = gap_run[3:0];
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      k       <= '0;
      arr_q   <= '0;
      right_q <= '0;
      out_idx <= 3'd7;
      err     <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      k     <= k_nx;
      err   <= accept && !ok;
      if (accept) begin
        arr_q   <= in_array;
        right_q <= in_right;
      end
      // Wraps 0 -> 7 after the last byte, ready for the next row.
      if (fire)
        out_idx <= out_idx - 3'd1;
    end
  end

endmodule

// File: tb/tb_capsule_8bit_expander.sv
module tb_capsule_8bit_expander;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_flag;
  logic [2:0]   in_left;
  logic [2:0]   in_right;
  logic [111:0] in_array;
  logic [3:0]   in_size;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic [2:0]   out_idx;
  logic         out_last;
  logic         err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  capsule_8bit_expander dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_flag   (in_flag),
    .in_left   (in_left),
    .in_right  (in_right),
    .in_array  (in_array),
    .in_size   (in_size),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .err       (err)
  );

  typedef struct {
    logic         flag;
    logic [2:0]   left;
    logic [2:0]   right;
    logic [3:0]   size;
    logic [111:0] arr;
  } cap_t;

  typedef struct {
    string        name;
    cap_t         c;
    logic [63:0]  exp_bytes;  // byte i at [8i+7:8i]
    bit           exp_ok;
    bit           rnd_rdy;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int run_of(input logic [111:0] a, input int k);
    return int'(a[k*14+8 +: 6]);
  endfunction

  function automatic logic [7:0] val_of(input logic [111:0] a, input int k);
    return a[k*14 +: 8];
  endfunction

  // Reference: validate by counting, then place each value into an 8-byte row.
  function automatic bit model(input cap_t c, output logic [63:0] bytes);
    int len;
    int pos;
    int sz;
    bytes = '0;
    if (!c.flag) return 1'b1;
    sz = int'(c.size);
    if (sz < 1 || sz > 8) return 1'b0;
    len = int'(c.left) + int'(c.right) + sz;
    for (int i = 0; i < sz - 1; i++) len += run_of(c.arr, i);
    if (run_of(c.arr, sz - 1) != 0) return 1'b0;
    if (len != 8) return 1'b0;
    pos = int'(c.right);
    for (int i = 0; i < sz; i++) begin
      bytes[pos*8 +: 8] = val_of(c.arr, i);
      pos += 1 + run_of(c.arr, i);
    end
    return 1'b1;
  endfunction

  // Packer: row of bytes -> capsule; unused fields get random garbage.
  function automatic cap_t encode(input logic [63:0] b);
    cap_t c;
    int   nz[$];
    c.flag  = 1'b0;
    c.left  = 3'($urandom);
    c.right = 3'($urandom);
    c.size  = 4'($urandom);
    c.arr   = {$urandom, $urandom, $urandom, 16'($urandom)};
    for (int i = 0; i < 8; i++)
      if (b[i*8 +: 8] != 8'h00) nz.push_back(i);
    if (nz.size() == 0) return c;
    c.flag  = 1'b1;
    c.right = 3'(nz[0]);
    c.left  = 3'(7 - nz[nz.size()-1]);
    c.size  = 4'(nz.size());
    for (int i = 0; i < nz.size(); i++)
      c.arr[i*14 +: 14] = {6'((i == nz.size()-1) ? 0 : nz[i+1] - nz[i] - 1), b[nz[i]*8 +: 8]};
    return c;
  endfunction

  // Called at a negedge. abort_after < 8 stops mid-row after that many bytes.
  task automatic run_cap(input string name, input cap_t c, input logic [63:0] exp_b,
                         input bit exp_ok, input bit rnd_rdy, input int abort_after);
    int         waitc;
    int         got;
    int         cyc;
    int         err_hits;
    bit         held;
    logic [7:0] h_data;
    logic [2:0] h_idx;
    logic       h_last;
    waitc = 0;
    while (!in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk({name, "_in_ready"}, in_ready, 1);
    in_flag  = c.flag;
    in_left  = c.left;
    in_right = c.right;
    in_size  = c.size;
    in_array = c.arr;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    if (!exp_ok) begin
      chk({name, "_err_pulse"}, err, 1);
      chk({name, "_no_valid"}, out_valid, 0);
      @(negedge clk);
      chk({name, "_err_clear"}, err, 0);
      chk({name, "_no_valid2"}, out_valid, 0);
      chk({name, "_ready_after_err"}, in_ready, 1);
      return;
    end
    chk({name, "_first_valid"}, out_valid, 1);
    got = 0; cyc = 0; err_hits = 0; held = 1'b0;
    h_data = '0; h_idx = '0; h_last = 1'b0;
    while (got < abort_after && cyc < 200) begin
      out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (err) err_hits++;
      if (held) begin
        chk({name, "_stall_data"}, out_data, h_data);
        chk({name, "_stall_idx"}, out_idx, h_idx);
        chk({name, "_stall_last"}, out_last, h_last);
      end
      if (!out_valid) begin
        chk({name, "_valid_gap"}, out_valid, 1);
        held = 1'b0;
      end else if (out_ready) begin
        chk($sformatf("%s_data%0d", name, got), out_data, exp_b[(7-got)*8 +: 8]);
        chk($sformatf("%s_idx%0d", name, got), out_idx, 7 - got);
        chk($sformatf("%s_last%0d", name, got), out_last, (got == 7) ? 1 : 0);
        got++;
        held = 1'b0;
      end else begin
        held = 1'b1;
        h_data = out_data; h_idx = out_idx; h_last = out_last;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    chk({name, "_bytes"}, got, abort_after);
    chk({name, "_err_quiet"}, err_hits, 0);
    if (abort_after < 8) return;
    if (!rnd_rdy) chk({name, "_period"}, cyc, 8);
    chk({name, "_idle_after"}, out_valid, 0);
    chk({name, "_ready_after"}, in_ready, 1);
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{"tp_basic",  '{1, 3'd2, 3'd1, 4'd2, {84'h0, 14'h005, 14'h303}},
                64'h0000_0500_0000_0300, 1, 0};
    vecs[1]  = '{"all_zero",  '{0, 3'd5, 3'd6, 4'hF, 112'hDEADBEEF_CAFEF00D_12345678_9ABC},
                64'h0, 1, 0};
    vecs[2]  = '{"full",      '{1, 3'd0, 3'd0, 4'd8, {14'h001, 14'h002, 14'h003, 14'h004,
                                                     14'h005, 14'h006, 14'h007, 14'h008}},
                64'h0102_0304_0506_0708, 1, 0};
    vecs[3]  = vecs[2];
    vecs[3].name = "full_b2b";
    vecs[4]  = '{"single",    '{1, 3'd7, 3'd0, 4'd1, {98'h0, 14'h07F}},
                64'h0000_0000_0000_007F, 1, 0};
    vecs[5]  = '{"bad_sum",   '{1, 3'd3, 3'd3, 4'd3, {70'h0, 14'h033, 14'h022, 14'h011}},
                64'h0, 0, 0};
    vecs[6]  = vecs[0];
    vecs[6].name = "after_bad";
    vecs[7]  = '{"zero_val",  '{1, 3'd0, 3'd0, 4'd8, {14'h001, 14'h002, 14'h003, 14'h004,
                                                     14'h000, 14'h006, 14'h007, 14'h008}},
                64'h0102_0304_0006_0708, 1, 0};
    vecs[8]  = '{"gap_trail", '{1, 3'd1, 3'd2, 4'd2, {84'h0, 14'h022, 14'h311}},
                64'h0022_0000_0011_0000, 1, 1};
    vecs[9]  = '{"last_run",  '{1, 3'd7, 3'd0, 4'd1, {98'h0, 14'h17F}},
                64'h0, 0, 0};
    vecs[10] = '{"size0",     '{1, 3'd4, 3'd4, 4'd0, 112'h0},
                64'h0, 0, 0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_flag = 1'b0; in_left = '0; in_right = '0; in_size = '0; in_array = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 7);
    chk("rst_out_last", out_last, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    foreach (vecs[i])
      run_cap(vecs[i].name, vecs[i].c, vecs[i].exp_bytes, vecs[i].exp_ok, vecs[i].rnd_rdy, 8);

    // Random stalls on the first vector, then reset after 4 bytes.
    run_cap("stall_rst", vecs[0].c, vecs[0].exp_bytes, 1, 1, 4);
    chk("mid_row_valid", out_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_idx", out_idx, 7);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_out_data", out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready_after", in_ready, 1);
    chk("mid_rst_idle_after", out_valid, 0);
    run_cap("after_rst", vecs[0].c, vecs[0].exp_bytes, 1, 0, 8);

    for (int n = 0; n < 40; n++) begin
      logic [63:0] b;
      logic [63:0] e;
      cap_t        c;
      bit          okm;
      for (int i = 0; i < 8; i++)
        b[i*8 +: 8] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
      c = encode(b);
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 2))
          0:       c.left  = c.left + 3'd1;
          1:       c.size  = c.size + 4'd1;
          default: c.right = c.right ^ 3'd1;
        endcase
      end
      okm = model(c, e);
      run_cap($sformatf("rnd%0d", n), c, e, okm, 1'(n % 2), 8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
